// File: rtl/maxpool2x2_stage.sv
`timescale 1ns/1ps
// maxpool2x2_stage
// S2 stage of the LeNet-5 accelerator: 2x2 / stride-2 signed int8 max-pool
// with optional ReLU. Reads the conv result from the source BRAM and writes
// the pooled maps, packed 4 px per word, to the destination BRAM.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   start           one-cycle start pulse, accepted only in IDLE or DONE
//   done            high from job completion until the next accepted start
//   BRAM_SRC_*      read port of the source BRAM (data valid 1 cycle after EN)
//   BRAM_DST_*      write port of the destination BRAM
//
// Each source word holds 4 adjacent pixels of one row. A top/bottom word
// pair yields 2 pooled pixels, so two pairs fill one destination word.
module maxpool2x2_stage #(
    parameter int          IN_H     = 28,
    parameter int          IN_W     = 28,
    parameter int          CH       = 6,
    parameter int          RELU     = 1,
    parameter logic [31:0] SRC_BASE = 32'h0,
    parameter logic [31:0] DST_BASE = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic [31:0] BRAM_SRC_ADDR,
    output logic        BRAM_SRC_EN,
    output logic [3:0]  BRAM_SRC_WE,
    input  logic [31:0] BRAM_SRC_DOUT,
    output logic [31:0] BRAM_DST_ADDR,
    output logic        BRAM_DST_EN,
    output logic [3:0]  BRAM_DST_WE,
    output logic [31:0] BRAM_DST_DIN
);

    localparam int WPR   = IN_W / 4;
    localparam int PAIRS = CH * (IN_H / 2) * WPR;

    localparam logic [31:0] ROW_W     = 32'(WPR);
    localparam logic [31:0] ROW_PAIR  = 32'(2 * WPR);
    localparam logic [31:0] LAST_J    = 32'(WPR - 1);
    localparam logic [31:0] LAST_PAIR = 32'(PAIRS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_TOP,
        RD_BOT,
        CMP,
        FLUSH,
        DONE
    } state_t;

    state_t state, state_nxt;

    // Row pairs never straddle a channel (IN_H is even), so a single running
    // word index of the top row walks across rows and channels alike.
    logic [31:0] col_j;
    logic [31:0] row_word;
    logic [31:0] pair_cnt;
    logic [31:0] dst_word;
    logic        half;
    logic        wr_pend;
    logic [31:0] pack;
    logic [31:0] top_p1;
    logic [31:0] src_word;
    logic [7:0]  pooled0;
    logic [7:0]  pooled1;
    logic        accept;

    function automatic logic signed [7:0] smax(input logic signed [7:0] a,
                                               input logic signed [7:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] relu_sat(input logic signed [7:0] v);
        if (RELU != 0 && v < 0)
            return 8'h00;
        return v;
    endfunction

    function automatic logic [7:0] pool4(input logic [7:0] t0, input logic [7:0] t1,
                                         input logic [7:0] b0, input logic [7:0] b1);
        return relu_sat(smax(smax(t0, t1), smax(b0, b1)));
    endfunction

    assign accept   = start && (state == IDLE || state == DONE);
    assign src_word = row_word + col_j + ((state == RD_BOT) ? ROW_W : 32'd0);

    // Bottom word is on BRAM_SRC_DOUT during CMP; top word was captured in RD_BOT.
    assign pooled0 = pool4(top_p1[7:0],   top_p1[15:8],  BRAM_SRC_DOUT[7:0],   BRAM_SRC_DOUT[15:8]);
    assign pooled1 = pool4(top_p1[23:16], top_p1[31:24], BRAM_SRC_DOUT[23:16], BRAM_SRC_DOUT[31:24]);

    assign BRAM_SRC_WE = 4'h0;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        done          = 1'b0;
        BRAM_SRC_EN   = 1'b0;
        BRAM_SRC_ADDR = 32'h0;
        BRAM_DST_EN   = 1'b0;
        BRAM_DST_WE   = 4'h0;
        BRAM_DST_ADDR = 32'h0;
        BRAM_DST_DIN  = 32'h0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = RD_TOP;
            end
            RD_TOP: begin
                BRAM_SRC_EN   = 1'b1;
                BRAM_SRC_ADDR = SRC_BASE + (src_word << 2);
                state_nxt     = RD_BOT;
            end
            RD_BOT: begin
                BRAM_SRC_EN   = 1'b1;
                BRAM_SRC_ADDR = SRC_BASE + (src_word << 2);
                state_nxt     = CMP;
            end
            CMP: begin
                state_nxt = (pair_cnt == LAST_PAIR) ? FLUSH : RD_TOP;
            end
            FLUSH: begin
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start)
                    state_nxt = RD_TOP;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A completed pack word goes out in the following RD_TOP or FLUSH cycle.
        if (wr_pend) begin
            BRAM_DST_EN   = 1'b1;
            BRAM_DST_WE   = 4'hF;
            BRAM_DST_ADDR = DST_BASE + (dst_word << 2);
            BRAM_DST_DIN  = pack;
        end
    end

    // Stage p1: top word captured while the bottom word is being read.
    always_ff @(posedge clk) begin
        if (state == RD_BOT)
            top_p1 <= BRAM_SRC_DOUT;
    end

    // Stage p2: pooled bytes shift into the pack register, counters advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_j    <= 32'd0;
            row_word <= 32'd0;
            pair_cnt <= 32'd0;
            dst_word <= 32'd0;
            half     <= 1'b0;
            wr_pend  <= 1'b0;
            pack     <= 32'h0;
        end else begin
            wr_pend <= 1'b0;
            if (wr_pend)
                dst_word <= dst_word + 32'd1;
            if (accept) begin
                col_j    <= 32'd0;
                row_word <= 32'd0;
                pair_cnt <= 32'd0;
                dst_word <= 32'd0;
                half     <= 1'b0;
                pack     <= 32'h0;
            end
            if (state == CMP) begin
                // Lower pixel index ends up in the lower byte after two shifts.
                pack     <= {pooled1, pooled0, pack[31:16]};
                half     <= ~half;
                wr_pend  <= half;
                pair_cnt <= pair_cnt + 32'd1;
                if (col_j == LAST_J) begin
                    col_j    <= 32'd0;
                    row_word <= row_word + ROW_PAIR;
                end else begin
                    col_j <= col_j + 32'd1;
                end
            end
        end
    end

endmodule
